// File: rtl/alu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if
// Bundles the operand stream, the parity-unit link and the result stream
// of the ALU operand sequencer.
//   in_data/in_valid/in_ready     : operand nibble stream (A first, then B)
//   a/b/E                         : operands and one-cycle enable to parity unit
//   ansA/ansB                     : combinational parity answers from the unit
//   par_a/par_b/res_valid/res_ready : registered result stream
//   op_count                      : wrap-around count of accepted results
// master = environment (source, parity unit, sink); slave = sequencer.
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             E;
  logic             ansA;
  logic             ansB;
  logic             par_a;
  logic             par_b;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_data, in_valid, ansA, ansB, res_ready,
    input  in_ready, a, b, E, par_a, par_b, res_valid, op_count
  );

  modport slave (
    input  in_data, in_valid, ansA, ansB, res_ready,
    output in_ready, a, b, E, par_a, par_b, res_valid, op_count
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
// Loads operand A then operand B from a valid/ready nibble stream, pulses
// the parity unit enable for one cycle, captures both parity answers and
// offers them downstream under valid/ready. Counts accepted results.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_operand_sequencer_if.slave (see interface header)
// Parameters:
//   CNT_W : width of the completed-operation counter (must match bus)
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  alu_operand_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_inReady;
  logic             w_enable;
  logic             w_resValid;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_parA;
  logic             r_parB;
  logic [CNT_W-1:0] r_opCount;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD_A;
    else        r_state <= w_stateNext;
  end

  // Next-state logic; EXEC always lasts exactly one cycle
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      LOAD_A: if (bus.in_valid)  w_stateNext = LOAD_B;
      LOAD_B: if (bus.in_valid)  w_stateNext = EXEC;
      EXEC:                      w_stateNext = RESULT;
      RESULT: if (bus.res_ready) w_stateNext = LOAD_A;
      default:                   w_stateNext = LOAD_A;
    endcase
  end

  // Handshake and enable outputs are decoded purely from the state
  always_comb begin
    w_inReady  = 1'b0;
    w_enable   = 1'b0;
    w_resValid = 1'b0;
    unique case (r_state)
      LOAD_A:  w_inReady  = 1'b1;
      LOAD_B:  w_inReady  = 1'b1;
      EXEC:    w_enable   = 1'b1;
      RESULT:  w_resValid = 1'b1;
      default: w_inReady  = 1'b1;
    endcase
  end

  // Operand, parity and counter registers; a/b/par hold until overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_parA    <= 1'b0;
      r_parB    <= 1'b0;
      r_opCount <= '0;
    end else begin
      if (r_state == LOAD_A && bus.in_valid) r_a <= bus.in_data;
      if (r_state == LOAD_B && bus.in_valid) r_b <= bus.in_data;
      if (r_state == EXEC) begin
        r_parA <= bus.ansA;
        r_parB <= bus.ansB;
      end
      if (r_state == RESULT && bus.res_ready) r_opCount <= r_opCount + 1'b1;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.E         = w_enable;
  assign bus.res_valid = w_resValid;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.par_a     = r_parA;
  assign bus.par_b     = r_parB;
  assign bus.op_count  = r_opCount;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_sequencer
// Drives operand pairs into the sequencer, models the parity unit and a
// cycle-level reference of the sequencer, and checks results via a
// scoreboard of expected parity pairs.
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.CNT_W(CNT_W)) bus ();

  // Parity unit: combinational XOR reduction, gated by the enable
  assign bus.ansA = bus.E ? ^bus.a : 1'b0;
  assign bus.ansB = bus.E ? ^bus.b : 1'b0;

  alu_operand_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectorCount = 0;
  int missCount   = 0;
  int ePulses     = 0;
  int handshakes  = 0;

  typedef struct packed {
    logic parA;
    logic parB;
  } result_t;

  result_t expQ[$];

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model of the sequencer, built from the operational description
  typedef enum int {M_A, M_B, M_EXEC, M_RES} mstate_t;
  mstate_t          mState;
  logic [3:0]       mA, mB;
  logic             mParA, mParB;
  logic [CNT_W-1:0] mCount;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState <= M_A;
      mA <= 4'h0; mB <= 4'h0; mParA <= 1'b0; mParB <= 1'b0; mCount <= '0;
    end else begin
      case (mState)
        M_A:    if (bus.in_valid) begin mA <= bus.in_data; mState <= M_B; end
        M_B:    if (bus.in_valid) begin mB <= bus.in_data; mState <= M_EXEC; end
        M_EXEC: begin mParA <= ^mA; mParB <= ^mB; mState <= M_RES; end
        M_RES:  if (bus.res_ready) begin mCount <= mCount + 1'b1; mState <= M_A; end
        default: mState <= M_A;
      endcase
    end
  end

  // Per-cycle output monitor and scoreboard pop on result handshake
  always @(negedge clk) begin
    result_t exp;
    checkOutput("in_ready",  bus.in_ready,  (mState == M_A || mState == M_B));
    checkOutput("E",         bus.E,         (mState == M_EXEC));
    checkOutput("res_valid", bus.res_valid, (mState == M_RES));
    checkOutput("a",         bus.a,         mA);
    checkOutput("b",         bus.b,         mB);
    checkOutput("par_a",     bus.par_a,     mParA);
    checkOutput("par_b",     bus.par_b,     mParB);
    checkOutput("op_count",  bus.op_count,  mCount);
    if (bus.E === 1'b1) ePulses++;
    if (rst_n && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      handshakes++;
      if (expQ.size() == 0) begin
        checkOutput("sb_empty", 32'd1, 32'd0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("sb_par_a", bus.par_a, exp.parA);
        checkOutput("sb_par_b", bus.par_b, exp.parB);
      end
    end
  end

  // Presents one nibble and waits (bounded) for it to be accepted
  task automatic sendNibble(input logic [3:0] d);
    bit done = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Loads an operand pair, with optional source stall between A and B
  task automatic applyStimulus(input logic [3:0] opA, input logic [3:0] opB,
                               input int stall);
    result_t r;
    sendNibble(opA);
    repeat (stall) begin
      @(negedge clk);
      checkOutput("stall_a_held", bus.a, opA);
      @(posedge clk);
      #1;
    end
    sendNibble(opB);
    r.parA = ^opA;
    r.parB = ^opB;
    expQ.push_back(r);
  endtask

  // Raises res_ready and waits (bounded) for the result handshake
  task automatic waitHandshake();
    bit done = 0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.res_valid) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("result_timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset pulse; any pending expectation is discarded
  task automatic pulseReset();
    #1 rst_n = 1'b0;
    expQ.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int e0, h0;
    logic [3:0] ra, rb;
    bus.in_data   = 4'h0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_op_count", bus.op_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_no_E", ePulses, 0);

    // Basic operation with res_ready already high
    bus.res_ready = 1'b1;
    e0 = ePulses;
    applyStimulus(4'b1011, 4'b0110, 0);
    @(negedge clk);
    checkOutput("basic_E", bus.E, 1);
    @(negedge clk);
    checkOutput("basic_par_a", bus.par_a, 1);
    checkOutput("basic_par_b", bus.par_b, 0);
    checkOutput("basic_a", bus.a, 4'b1011);
    checkOutput("basic_b", bus.b, 4'b0110);
    @(negedge clk);
    checkOutput("basic_count", bus.op_count, 1);
    checkOutput("basic_one_E", ePulses - e0, 1);
    @(posedge clk);
    #1;

    // Backpressure
    bus.res_ready = 1'b0;
    e0 = ePulses;
    applyStimulus(4'b1111, 4'b0001, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("bp_valid", bus.res_valid, 1);
    checkOutput("bp_par_a", bus.par_a, 0);
    checkOutput("bp_par_b", bus.par_b, 1);
    checkOutput("bp_one_E", ePulses - e0, 1);
    waitHandshake();
    @(negedge clk);
    checkOutput("bp_back_to_load", bus.in_ready, 1);
    checkOutput("bp_count", bus.op_count, 2);
    @(posedge clk);
    #1;

    // Source stall between A and B
    applyStimulus(4'b0111, 4'b1001, 3);
    waitHandshake();
    checkOutput("stall_count", bus.op_count, 3);

    // Reset during EXEC
    bus.res_ready = 1'b0;
    h0 = handshakes;
    applyStimulus(4'b0011, 4'b0100, 0);
    pulseReset();
    checkOutput("rst_exec_count", bus.op_count, 0);
    checkOutput("rst_exec_no_hs", handshakes - h0, 0);

    // Reset during RESULT
    applyStimulus(4'b1000, 4'b1100, 0);
    @(posedge clk);
    #1;
    checkOutput("in_result", bus.res_valid, 1);
    pulseReset();
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_res_a", bus.a, 0);
    checkOutput("rst_res_no_hs", handshakes - h0, 0);

    // Fresh pair after reset loads from A
    applyStimulus(4'b0101, 4'b1110, 0);
    waitHandshake();
    checkOutput("post_rst_a", bus.a, 4'b0101);
    checkOutput("post_rst_count", bus.op_count, 1);

    // Counter wrap: 254 more operations reach 255, one more wraps to 0
    for (int i = 0; i < 254; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      applyStimulus(ra, rb, 0);
      waitHandshake();
    end
    checkOutput("wrap_255", bus.op_count, 255);
    applyStimulus(4'b0010, 4'b1101, 0);
    waitHandshake();
    checkOutput("wrap_0", bus.op_count, 0);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream sequencing stage for the ALU parity (odd/even) unit. It accepts operand nibbles over a valid/ready stream, loads operand A then operand B, and pulses the parity unit's enable for exactly one cycle. It registers the two parity results and presents them downstream under a valid/ready handshake. It also keeps a wrap-around count of completed operations.

## Interface
Parameters:
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_data  input  4  operand nibble; the first accepted nibble is A, the second is B.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  sequencer accepts a nibble this cycle.
- a  output  4  registered operand A, drives the parity unit's a input.
- b  output  4  registered operand B, drives the parity unit's b input.
- E  output  1  parity unit enable; high for exactly one cycle per operation.
- ansA  input  1  parity of a, from the parity unit; combinational and gated by E.
- ansB  input  1  parity of b, from the parity unit; combinational and gated by E.
- par_a  output  1  registered parity of A.
- par_b  output  1  registered parity of B.
- res_valid  output  1  par_a and par_b are valid.
- res_ready  input  1  downstream accepts the result.
- op_count  output  CNT_W  number of results accepted downstream, modulo 2^CNT_W.

## Operation
The block is a four-state FSM: LOAD_A, LOAD_B, EXEC, RESULT. The reset state is LOAD_A.

- LOAD_A: in_ready=1. When in_valid && in_ready, register a <= in_data and move to LOAD_B.
- LOAD_B: in_ready=1. When in_valid && in_ready, register b <= in_data and move to EXEC.
- EXEC: in_ready=0 and E=1, both combinational from state.
  - At the closing edge, register par_a <= ansA and par_b <= ansB.
  - Move to RESULT unconditionally.
- RESULT: res_valid=1, in_ready=0, E=0. par_a and par_b hold.
  - When res_ready=1: op_count increments, wrapping from 2^CNT_W-1 to 0, and the FSM moves to LOAD_A.
- a and b hold their values until overwritten by a new load. They are not cleared on leaving RESULT.
- par_a and par_b hold until the next EXEC. They stay readable after the handshake, but are meaningful only while res_valid=1.
- E is never high outside EXEC. As a result, the parity unit outputs 0 in every other state.
- Holding in_valid=1 continuously loads back-to-back nibbles, one per cycle, in LOAD_A and LOAD_B. Nibbles presented in EXEC or RESULT are not consumed; the source must hold them.
- in_valid low in LOAD_A or LOAD_B: the FSM stalls indefinitely. Already-loaded a is retained.
- res_ready held high before RESULT has no effect until RESULT is entered.
- Reset asserted in any state, including mid-operation:
  - State goes to LOAD_A immediately and asynchronously.
  - a, b, par_a, par_b and op_count are cleared to 0. res_valid and E go to 0, and in_ready goes to 1.
  - A partially loaded operand pair is discarded.
- There is no bypass. A result handshake and a new nibble cannot occur in the same cycle.

## Timing
- Reset values: in_ready=1, a=0, b=0, E=0, par_a=0, par_b=0, res_valid=0, op_count=0.
- With the B-nibble accepted at edge N: E=1 during cycle N..N+1, and par_a/par_b are registered at edge N+1.
- res_valid=1 from edge N+1 until the edge where res_ready=1 is sampled.
- Minimum operation period is 4 cycles: LOAD_A, LOAD_B, EXEC, RESULT with res_ready=1.
- ansA and ansB must settle within the EXEC cycle. The parity unit is purely combinational, so there is no extra latency.
- op_count updates at the same edge as the result handshake and is visible the following cycle.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: rst_n low -> all outputs at their reset values, in_ready=1. Release reset and hold in_valid=0 for 10 cycles -> state stays LOAD_A and E never pulses.
- Basic operation: send 4'b1011 then 4'b0110 back-to-back with res_ready=1 -> a=1011, b=0110, a single-cycle E pulse, then res_valid for 1 cycle with par_a=1, par_b=0, and op_count=1.
- Backpressure: A=4'b1111, B=4'b0001, res_ready=0 for 5 cycles -> res_valid stays high, par_a=0 and par_b=1 stable, in_ready=0 throughout, E pulsed only once. Raising res_ready then gives return to LOAD_A.
- Source stall: A accepted, then in_valid low for 3 cycles -> stays in LOAD_B, a retained, E=0. Supplying B resumes a normal EXEC.
- Counter wrap: run 256 operations with CNT_W=8 -> op_count reaches 255 and then reads 0.
- Reset mid-operation: assert rst_n low during EXEC and, separately, during RESULT -> immediate return to reset values and no result handshake. The next pair loads from A correctly.
